// File: rtl/bldc_hall_sampler_pkg.sv
// Shared types and defaults for the BLDC hall sampling scheduler.
package bldc_hall_sampler_pkg;

  localparam int DEF_NUM_MOTORS    = 5;
  localparam int DEF_COUNTER_WIDTH = 8;
  localparam int DEF_PERIOD_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SCAN    = 2'd2
  } state_t;

  // Low bit of motor slice within the flattened counts bus.
  function automatic int slice_lo(input int motor, input int width);
    return motor * width;
  endfunction

endpackage

// File: rtl/bldc_hall_sampler_timer.sv
// Sample-period down-counter. Ticks at terminal count or on a sample_now
// strobe; either event reloads the period, so a new period value only
// lands at the next reload.
module hall_sample_timer
  import bldc_hall_sampler_pkg::*;
#(
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    sample_now,
  output logic                    tick
);

  logic [PERIOD_WIDTH-1:0] remaining;

  assign tick = sample_now || (remaining == '0);

  // Count down, reloading on every tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= period;
    end else if (tick) begin
      remaining <= period;
    end else begin
      remaining <= remaining - PERIOD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/bldc_hall_sampler.sv
// Periodic hall-counter sampler: captures every counter in one cycle, then
// streams one signed position delta per enabled motor over valid/ready.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a tick; ticks with no motor enabled are ignored
// ST_CAPTURE | one cycle: snapshot all counts, latch the frame's enable mask
// ST_SCAN    | present one delta per enabled motor, advance on handshake
module bldc_hall_sampler
  import bldc_hall_sampler_pkg::*;
#(
  parameter  int NUM_MOTORS    = DEF_NUM_MOTORS,
  parameter  int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter  int PERIOD_WIDTH  = DEF_PERIOD_WIDTH,
  localparam int IDX_W         = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [PERIOD_WIDTH-1:0]             period,
  input  logic [NUM_MOTORS-1:0]               enable,
  input  logic                                sample_now,
  input  logic [NUM_MOTORS*COUNTER_WIDTH-1:0] counts,
  output logic [NUM_MOTORS-1:0]               counter_reset,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [IDX_W-1:0]                    out_motor,
  output logic [COUNTER_WIDTH-1:0]            out_delta,
  output logic                                out_last,
  output logic                                overrun,
  input  logic                                overrun_clr
);

  state_t                   state;
  logic [NUM_MOTORS-1:0]    frame_mask;
  logic [COUNTER_WIDTH-1:0] cap  [NUM_MOTORS];
  logic [COUNTER_WIDTH-1:0] prev [NUM_MOTORS];
  logic                     tick;
  logic                     accept;
  logic [IDX_W-1:0]         first_idx;
  logic [IDX_W-1:0]         next_idx;
  logic                     first_last;
  logic                     next_last;

  hall_sample_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .period     (period),
    .sample_now (sample_now),
    .tick       (tick)
  );

  assign accept = out_valid && out_ready;

  // Single shared subtractor; modular wrap gives the signed delta.
  assign out_delta = cap[out_motor] - prev[out_motor];

  // Priority encoders: first motor of a new frame, next motor after the current one.
  always_comb begin
    first_idx  = '0;
    next_idx   = out_motor;
    first_last = 1'b1;
    next_last  = 1'b1;
    for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
      if (enable[i]) first_idx = IDX_W'(i);
      if (frame_mask[i] && (i > int'(out_motor))) next_idx = IDX_W'(i);
    end
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (enable[i] && (i > int'(first_idx))) first_last = 1'b0;
      if (frame_mask[i] && (i > int'(next_idx))) next_last = 1'b0;
    end
  end

  // Frame sequencing with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      frame_mask <= '0;
      out_valid  <= 1'b0;
      out_motor  <= '0;
      out_last   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick && (|enable)) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          frame_mask <= enable;
          if (|enable) begin
            out_motor <= first_idx;
            out_last  <= first_last;
            out_valid <= 1'b1;
            state     <= ST_SCAN;
          end else begin
            // Mask emptied between tick and capture: nothing to send.
            state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              out_motor <= next_idx;
              out_last  <= next_last;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Snapshot and previous-sample registers. A disabled motor's prev is held
  // at zero, except while it still belongs to the frame being streamed so
  // that a mid-frame disable cannot corrupt words already promised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        cap[i]  <= '0;
        prev[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        if (state == ST_CAPTURE) cap[i] <= counts[slice_lo(i, COUNTER_WIDTH) +: COUNTER_WIDTH];
        if (accept && (int'(out_motor) == i)) begin
          prev[i] <= cap[i];
        end else if (!enable[i] && !((state == ST_SCAN) && frame_mask[i])) begin
          prev[i] <= '0;
        end
      end
    end
  end

  // Counter clear lines and sticky overrun (set beats clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_reset <= '1;
      overrun       <= 1'b0;
    end else begin
      counter_reset <= ~enable;
      if (tick && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bldc_hall_sampler.sv
// Bench for bldc_hall_sampler: frame-level reference model of deltas.
module tb_bldc_hall_sampler;

  localparam int NM = 5;
  localparam int W  = 8;
  localparam int PW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [PW-1:0]   period;
  logic [NM-1:0]   enable;
  logic            sample_now;
  logic [NM*W-1:0] counts;
  logic [NM-1:0]   counter_reset;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_motor;
  logic [W-1:0]    out_delta;
  logic            out_last;
  logic            overrun;
  logic            overrun_clr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;

  logic [W-1:0] m_cnt  [NM];
  logic [W-1:0] m_prev [NM];

  typedef struct {
    int           motor;
    logic [W-1:0] delta;
    bit           last;
  } word_t;
  word_t exp_q[$];

  bldc_hall_sampler dut (
    .clk           (clk),
    .reset         (reset),
    .period        (period),
    .enable        (enable),
    .sample_now    (sample_now),
    .counts        (counts),
    .counter_reset (counter_reset),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_motor     (out_motor),
    .out_delta     (out_delta),
    .out_last      (out_last),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    counts = '0;
    for (int i = 0; i < NM; i++) counts[i*W +: W] = m_cnt[i];
  end

  // Disabled motors restart from zero.
  function automatic void set_enable(input logic [NM-1:0] v);
    enable = v;
    for (int i = 0; i < NM; i++) if (!v[i]) m_prev[i] = '0;
  endfunction

  // Expected frame: one word per enabled motor, ascending, delta = count - prev mod 2^W.
  function automatic void build_frame();
    int    last_i;
    word_t w;
    last_i = -1;
    for (int i = 0; i < NM; i++) if (enable[i]) last_i = i;
    for (int i = 0; i < NM; i++) begin
      if (enable[i]) begin
        w.motor = i;
        w.delta = m_cnt[i] - m_prev[i];
        w.last  = (i == last_i);
        exp_q.push_back(w);
        m_prev[i] = m_cnt[i];
      end
    end
  endfunction

  function automatic void randomize_counts();
    for (int i = 0; i < NM; i++) m_cnt[i] = 8'($urandom);
  endfunction

  task automatic pulse_sample();
    @(negedge clk);
    sample_now = 1'b1;
    @(negedge clk);
    sample_now = 1'b0;
  endtask

  // Consume one expected frame, comparing every cycle a word is presented.
  task automatic collect_frame(input int stall_at, input int stall_len, input bit rnd,
                               input int wait_budget);
    int n, stall, waited;
    bit done, seen;
    n = 0; stall = 0; waited = 0; done = 0; seen = 0;
    while (!done) begin
      @(negedge clk);
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          rise_cyc = cyc;
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got motor=%0d delta=%0d, no word expected", out_motor, out_delta);
          out_ready = 1'b1;
          done = 1;
        end else begin
          if (out_motor !== 3'(exp_q[0].motor) || out_delta !== exp_q[0].delta ||
              out_last !== exp_q[0].last) begin
            errors++;
            $display("FAIL word: got motor=%0d delta=%0d last=%0d, want motor=%0d delta=%0d last=%0d",
                     out_motor, out_delta, out_last, exp_q[0].motor, exp_q[0].delta, exp_q[0].last);
          end
          if (n == stall_at && stall < stall_len) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            n++;
            if (exp_q.size() == 0) done = 1;
          end
        end
      end else begin
        if (seen) begin
          checks++;
          errors++;
          $display("FAIL valid_drop: out_valid=0 with %0d words outstanding", exp_q.size());
          done = 1;
        end else begin
          waited++;
          if (waited > wait_budget) begin
            checks++;
            errors++;
            $display("FAIL timeout: no out_valid within %0d cycles, want %0d words", wait_budget, exp_q.size());
            done = 1;
          end
        end
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: out_valid=%0b, want 0", out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    period = 16'd99;
    sample_now = 1'b0;
    out_ready = 1'b1;
    overrun_clr = 1'b0;
    m_cnt[0] = 8'd3; m_cnt[1] = 8'd0; m_cnt[2] = 8'd7; m_cnt[3] = 8'd0; m_cnt[4] = 8'd250;
    for (int i = 0; i < NM; i++) m_prev[i] = '0;
    set_enable(5'b10101);
    repeat (3) @(negedge clk);
    checks++;
    if (counter_reset !== 5'h1f) begin errors++; $display("FAIL rst_counter_reset: got %b want 11111", counter_reset); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    checks++;
    if (out_motor !== 3'd0) begin errors++; $display("FAIL rst_out_motor: got %0d want 0", out_motor); end
    checks++;
    if (out_delta !== 8'd0) begin errors++; $display("FAIL rst_out_delta: got %0d want 0", out_delta); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (counter_reset !== 5'b01010) begin errors++; $display("FAIL post_rst_counter_reset: got %b want 01010", counter_reset); end
  endtask

  task automatic test_basic_frame();
    int first_rise;
    build_frame();
    collect_frame(-1, 0, 0, 200);
    first_rise = rise_cyc;
    period = 16'hFFFF;
    build_frame();
    collect_frame(-1, 0, 0, 200);
    checks++;
    if (rise_cyc - first_rise != 100) begin
      errors++;
      $display("FAIL period_spacing: got %0d cycles want 100", rise_cyc - first_rise);
    end
  endtask

  task automatic test_latency();
    randomize_counts();
    out_ready = 1'b0;
    pulse_sample();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_capture: out_valid=%b want 0", out_valid); end
    build_frame();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: out_valid=%b want 1", out_valid); end
    collect_frame(-1, 0, 0, 10);
  endtask

  task automatic test_wrap();
    set_enable(5'b00001);
    m_cnt[0] = 8'd250;
    pulse_sample(); build_frame(); collect_frame(-1, 0, 0, 10);
    m_cnt[0] = 8'd4;
    pulse_sample(); build_frame(); collect_frame(-1, 0, 0, 10);
    m_cnt[0] = 8'd250;
    pulse_sample(); build_frame(); collect_frame(-1, 0, 0, 10);
  endtask

  task automatic test_backpressure();
    set_enable(5'b11111);
    randomize_counts();
    pulse_sample(); build_frame();
    collect_frame(2, 20, 0, 10);
  endtask

  task automatic test_enable();
    set_enable(5'b11111);
    randomize_counts();
    m_cnt[1] = 8'd9;
    pulse_sample(); build_frame(); collect_frame(-1, 0, 0, 10);
    @(negedge clk);
    set_enable(5'b11101);
    @(negedge clk);
    checks++;
    if (counter_reset !== 5'b00010) begin errors++; $display("FAIL disable_clear: got %b want 00010", counter_reset); end
    randomize_counts();
    pulse_sample(); build_frame(); collect_frame(-1, 0, 0, 10);
    m_cnt[1] = 8'd5;
    @(negedge clk);
    set_enable(5'b11111);
    @(negedge clk);
    checks++;
    if (counter_reset !== 5'b00000) begin errors++; $display("FAIL reenable_clear: got %b want 00000", counter_reset); end
    pulse_sample(); build_frame(); collect_frame(-1, 0, 0, 10);
  endtask

  task automatic test_overrun();
    set_enable(5'b00111);
    randomize_counts();
    out_ready = 1'b0;
    period = 16'd2;
    pulse_sample(); build_frame();
    repeat (10) @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    period = 16'hFFFF;
    repeat (6) @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    sample_now = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    sample_now = 1'b0;
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins: got %b want 1", overrun); end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear2: got %b want 0", overrun); end
    collect_frame(-1, 0, 0, 5);
    set_enable(5'b00000);
    pulse_sample();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_tick_no_frame: out_valid=%b want 0", out_valid); end
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL idle_tick_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_async_reset();
    set_enable(5'b11010);
    randomize_counts();
    out_ready = 1'b0;
    pulse_sample(); build_frame();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b want 0", out_valid); end
    checks++;
    if (counter_reset !== 5'h1f) begin errors++; $display("FAIL async_rst_clear: got %b want 11111", counter_reset); end
    checks++;
    if (out_last !== 1'b0) begin errors++; $display("FAIL async_rst_last: got %b want 0", out_last); end
    exp_q.delete();
    for (int i = 0; i < NM; i++) m_prev[i] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (counter_reset !== 5'b00101) begin errors++; $display("FAIL post_async_clear: got %b want 00101", counter_reset); end
    randomize_counts();
    out_ready = 1'b1;
    pulse_sample(); build_frame(); collect_frame(-1, 0, 0, 10);
  endtask

  task automatic test_random();
    logic [NM-1:0] en;
    for (int f = 0; f < 12; f++) begin
      en = 5'($urandom_range(0, 31));
      @(negedge clk);
      set_enable(en);
      randomize_counts();
      pulse_sample();
      if (en != '0) begin
        build_frame();
        collect_frame(-1, 0, 1, 10);
      end else begin
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_empty_mask: out_valid=%b want 0", out_valid); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_latency();
    test_wrap();
    test_backpressure();
    test_enable();
    test_overrun();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
